hazard_stall_controller: RTL and testbench

//  Pipeline sequencing controller for the 5-stage forwarding/stalling core.
//  - Detects load-use hazards the forwarding unit cannot cover and inserts a one-cycle bubble.
//  - Squashes wrong-path instructions on a taken branch resolved in EX.
//  - Freezes the pipeline while data memory is not ready.
//  - Keeps saturating stall and flush performance counters.

---
 rtl/hazard_stall_controller.sv | 155 +++++++++++++++
 tb/tb_hazard_stall_controller.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Pipeline sequencing controller for a 5-stage forwarding/stalling core.
//   It inserts a one-cycle bubble on load-use hazards and squashes wrong-path
//   instructions on a taken branch resolved in EX. It freezes the pipeline while
//   data memory is busy and enters a sticky ERROR state on memory timeout. It
//   also keeps saturating stall and flush counters.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   rs1IFID/rs2IFID: source registers of the instruction in ID
//   useRs1/useRs2  : ID instruction actually reads rs1/rs2
//   rdIDEX         : destination register of the instruction in EX
//   MemReadIDEX    : EX instruction is a load
//   branchTakenEX  : branch/jump in EX resolved taken
//   memReq         : MEM-stage instruction accesses data memory
//   memReady       : data memory completes the access this cycle
//   PCWrite        : PC register enable
//   IFIDWrite      : IF/ID register enable
//   IFIDFlush      : load NOP into IF/ID
//   IDEXFlush      : load bubble into ID/EX
//   pipeFreeze     : hold ID/EX and EX/MEM, bubble into MEM/WB
//   halt           : sticky memory-timeout error (registered)
//   stall_cycles   : saturating count of stalled cycles (registered)
//   flush_count    : saturating count of branch flushes (registered)
module hazard_stall_controller #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1IFID,
    input  logic [4:0]       rs2IFID,
    input  logic             useRs1,
    input  logic             useRs2,
    input  logic [4:0]       rdIDEX,
    input  logic             MemReadIDEX,
    input  logic             branchTakenEX,
    input  logic             memReq,
    input  logic             memReady,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             pipeFreeze,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT) + 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StError
    } state_e;

    state_e            state_q;
    logic [WaitW-1:0]  wait_cnt_q;
    logic              halt_q;
    logic [CNT_W-1:0]  stall_cycles_q;
    logic [CNT_W-1:0]  flush_count_q;

    logic freeze;
    logic load_use;
    logic branch_act;
    logic load_use_act;

    // Frozen cycles defer branch/load-use; their stage registers are held, so
    // they re-evaluate on the release cycle.
    always_comb begin
        freeze = ((state_q == StRun) && memReq && !memReady) ||
                 ((state_q == StMemWait) && !memReady) ||
                 (state_q == StError);
        load_use = MemReadIDEX && (rdIDEX != 5'd0) &&
                   ((useRs1 && (rdIDEX == rs1IFID)) || (useRs2 && (rdIDEX == rs2IFID)));
        branch_act   = !freeze && branchTakenEX;
        load_use_act = !freeze && !branchTakenEX && load_use;
    end

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        pipeFreeze = 1'b0;
        if (rst) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end else if (freeze) begin
            pipeFreeze = 1'b1;
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
        end else if (branch_act) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (load_use_act) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            wait_cnt_q     <= '0;
            halt_q         <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    // A single-cycle memory (ready in the request cycle) stays in RUN.
                    if (memReq && !memReady) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= WaitW'(1);
                    end
                end
                StMemWait: begin
                    if (memReady) begin
                        state_q    <= StRun;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WaitLast) begin
                        state_q <= StError;
                        halt_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WaitW'(1);
                    end
                end
                StError: begin
                    state_q <= StError;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase

            if ((freeze || load_use_act) && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (branch_act && (flush_count_q != {CNT_W{1'b1}})) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign halt         = halt_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1IFID;
    logic [4:0]  rs2IFID;
    logic        useRs1;
    logic        useRs2;
    logic [4:0]  rdIDEX;
    logic        MemReadIDEX;
    logic        branchTakenEX;
    logic        memReq;
    logic        memReady;

    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeFreeze, halt;
    logic [15:0] stall_cycles, flush_count;

    logic        p2_pcw, p2_ifw, p2_iff, p2_idf, p2_frz, p2_halt;
    logic [1:0]  p2_stall, p2_flush;

    logic [4:0]  ctrl;
    assign ctrl = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeFreeze};

    int checks;
    int errors;

    hazard_stall_controller #(.MAX_WAIT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rs1IFID(rs1IFID), .rs2IFID(rs2IFID),
        .useRs1(useRs1), .useRs2(useRs2), .rdIDEX(rdIDEX), .MemReadIDEX(MemReadIDEX),
        .branchTakenEX(branchTakenEX), .memReq(memReq), .memReady(memReady),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush), .pipeFreeze(pipeFreeze), .halt(halt),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Narrow-counter instance to reach saturation naturally.
    hazard_stall_controller #(.MAX_WAIT(16), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .rs1IFID(rs1IFID), .rs2IFID(rs2IFID),
        .useRs1(useRs1), .useRs2(useRs2), .rdIDEX(rdIDEX), .MemReadIDEX(MemReadIDEX),
        .branchTakenEX(branchTakenEX), .memReq(memReq), .memReady(memReady),
        .PCWrite(p2_pcw), .IFIDWrite(p2_ifw), .IFIDFlush(p2_iff),
        .IDEXFlush(p2_idf), .pipeFreeze(p2_frz), .halt(p2_halt),
        .stall_cycles(p2_stall), .flush_count(p2_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and step just past it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rs1IFID = 5'd0; rs2IFID = 5'd0; useRs1 = 1'b0; useRs2 = 1'b0;
        rdIDEX = 5'd0; MemReadIDEX = 1'b0; branchTakenEX = 1'b0;
        memReq = 1'b0; memReady = 1'b0;
    endtask

    task automatic set_load_use();
        MemReadIDEX = 1'b1; rdIDEX = 5'd5; rs1IFID = 5'd5; useRs1 = 1'b1;
        rs2IFID = 5'd7; useRs2 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        cyc();
        cyc();
        checks++;
        if (ctrl !== 5'b00010) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, 5'b00010);
        end
        checks++;
        if ({halt, stall_cycles, flush_count} !== 33'd0) begin
            errors++; $display("FAIL reset_regs: got halt=%b stall=%0d flush=%0d expected 0/0/0",
                               halt, stall_cycles, flush_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ctrl !== 5'b11000) begin
            errors++; $display("FAIL post_reset_default: got %b expected %b", ctrl, 5'b11000);
        end
        cyc();
    endtask

    task automatic test_load_use();
        set_load_use();
        #1;
        checks++;
        if (ctrl !== 5'b00010) begin
            errors++; $display("FAIL load_use_rs1: got %b expected %b", ctrl, 5'b00010);
        end
        cyc();
        set_idle();
        #1;
        checks++;
        if (ctrl !== 5'b11000) begin
            errors++; $display("FAIL load_use_one_bubble: got %b expected %b", ctrl, 5'b11000);
        end
        checks++;
        if (stall_cycles !== 16'd1) begin
            errors++; $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
        end
        // Match through rs2 only.
        MemReadIDEX = 1'b1; rdIDEX = 5'd7; rs1IFID = 5'd3; useRs1 = 1'b1;
        rs2IFID = 5'd7; useRs2 = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b00010) begin
            errors++; $display("FAIL load_use_rs2: got %b expected %b", ctrl, 5'b00010);
        end
        cyc();
        set_idle();
        #1;
        checks++;
        if (stall_cycles !== 16'd2) begin
            errors++; $display("FAIL load_use_rs2_count: got %0d expected 2", stall_cycles);
        end
    endtask

    task automatic test_no_stall();
        MemReadIDEX = 1'b1; rdIDEX = 5'd0; rs1IFID = 5'd0; useRs1 = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b11000) begin
            errors++; $display("FAIL no_stall_rd0: got %b expected %b", ctrl, 5'b11000);
        end
        cyc();
        MemReadIDEX = 1'b1; rdIDEX = 5'd5; rs1IFID = 5'd5; useRs1 = 1'b0;
        rs2IFID = 5'd6; useRs2 = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b11000) begin
            errors++; $display("FAIL no_stall_userefs: got %b expected %b", ctrl, 5'b11000);
        end
        cyc();
        MemReadIDEX = 1'b0; rdIDEX = 5'd5; rs1IFID = 5'd5; useRs1 = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b11000) begin
            errors++; $display("FAIL no_stall_not_load: got %b expected %b", ctrl, 5'b11000);
        end
        cyc();
        set_idle();
        #1;
        checks++;
        if (stall_cycles !== 16'd2) begin
            errors++; $display("FAIL no_stall_count: got %0d expected 2", stall_cycles);
        end
    endtask

    task automatic test_branch();
        set_load_use();
        branchTakenEX = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b11110) begin
            errors++; $display("FAIL branch_over_load_use: got %b expected %b", ctrl, 5'b11110);
        end
        cyc();
        set_idle();
        #1;
        checks++;
        if ({flush_count, stall_cycles} !== {16'd1, 16'd2}) begin
            errors++; $display("FAIL branch_counts: got flush=%0d stall=%0d expected 1/2",
                               flush_count, stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        memReq = 1'b1; memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // Middle cycle also carries a branch + hazard that must be deferred.
            branchTakenEX = (i == 1);
            if (i == 1) set_load_use();
            #1;
            checks++;
            if (ctrl !== 5'b00001) begin
                errors++; $display("FAIL mem_freeze_%0d: got %b expected %b", i, ctrl, 5'b00001);
            end
            cyc();
            MemReadIDEX = 1'b0; useRs1 = 1'b0; useRs2 = 1'b0;
        end
        // Release cycle with a pending branch: branch priority applies at once.
        memReady = 1'b1; branchTakenEX = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b11110) begin
            errors++; $display("FAIL mem_release_branch: got %b expected %b", ctrl, 5'b11110);
        end
        cyc();
        set_idle();
        #1;
        checks++;
        if (ctrl !== 5'b11000) begin
            errors++; $display("FAIL mem_back_to_run: got %b expected %b", ctrl, 5'b11000);
        end
        checks++;
        if ({stall_cycles, flush_count} !== {16'd5, 16'd2}) begin
            errors++; $display("FAIL mem_counts: got stall=%0d flush=%0d expected 5/2",
                               stall_cycles, flush_count);
        end
        // Single-cycle memory never leaves RUN.
        memReq = 1'b1; memReady = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b11000) begin
            errors++; $display("FAIL mem_single_cycle: got %b expected %b", ctrl, 5'b11000);
        end
        cyc();
        set_idle();
        #1;
        checks++;
        if ({ctrl, stall_cycles} !== {5'b11000, 16'd5}) begin
            errors++; $display("FAIL mem_single_after: got ctrl=%b stall=%0d expected 11000/5",
                               ctrl, stall_cycles);
        end
    endtask

    task automatic test_timeout();
        memReq = 1'b1; memReady = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            #1;
            if (i == 16) begin
                checks++;
                if ({pipeFreeze, halt} !== 2'b10) begin
                    errors++; $display("FAIL timeout_before: got freeze=%b halt=%b expected 1/0",
                                       pipeFreeze, halt);
                end
            end
            cyc();
        end
        checks++;
        if ({halt, stall_cycles} !== {1'b1, 16'd21}) begin
            errors++; $display("FAIL timeout_halt: got halt=%b stall=%0d expected 1/21",
                               halt, stall_cycles);
        end
        // ERROR ignores memReady and stays frozen.
        memReq = 1'b0; memReady = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b00001) begin
            errors++; $display("FAIL error_freeze: got %b expected %b", ctrl, 5'b00001);
        end
        cyc();
        checks++;
        if ({halt, stall_cycles} !== {1'b1, 16'd22}) begin
            errors++; $display("FAIL error_sticky: got halt=%b stall=%0d expected 1/22",
                               halt, stall_cycles);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b00010) begin
            errors++; $display("FAIL error_rst_ctrl: got %b expected %b", ctrl, 5'b00010);
        end
        cyc();
        rst = 1'b0;
        set_idle();
        #1;
        checks++;
        if ({ctrl, halt, stall_cycles, flush_count} !== {5'b11000, 1'b0, 16'd0, 16'd0}) begin
            errors++; $display("FAIL error_rst_clear: got ctrl=%b halt=%b stall=%0d flush=%0d expected 11000/0/0/0",
                               ctrl, halt, stall_cycles, flush_count);
        end
    endtask

    task automatic test_reset_mid_wait();
        memReq = 1'b1; memReady = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        memReq = 1'b0; memReady = 1'b0;
        #1;
        checks++;
        if (ctrl !== 5'b11000) begin
            errors++; $display("FAIL rst_mid_wait: got %b expected %b", ctrl, 5'b11000);
        end
        // Fresh wait must restart its counting from scratch.
        memReq = 1'b1;
        cyc();
        memReady = 1'b1;
        #1;
        checks++;
        if (ctrl !== 5'b11000) begin
            errors++; $display("FAIL rst_wait_release: got %b expected %b", ctrl, 5'b11000);
        end
        cyc();
        set_idle();
        #1;
        checks++;
        if (stall_cycles !== 16'd1) begin
            errors++; $display("FAIL rst_wait_count: got %0d expected 1", stall_cycles);
        end
    endtask

    task automatic test_saturation();
        // Narrow instance starts at 1, same as the main one.
        set_load_use();
        cyc();
        #1;
        checks++;
        if (p2_stall !== 2'd2) begin
            errors++; $display("FAIL sat2_stall_pre: got %0d expected 2", p2_stall);
        end
        cyc();
        cyc();
        cyc();
        set_idle();
        #1;
        checks++;
        if ({p2_stall, stall_cycles} !== {2'd3, 16'd5}) begin
            errors++; $display("FAIL sat2_stall: got narrow=%0d wide=%0d expected 3/5",
                               p2_stall, stall_cycles);
        end
        branchTakenEX = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        branchTakenEX = 1'b0;
        #1;
        checks++;
        if ({p2_flush, flush_count} !== {2'd3, 16'd4}) begin
            errors++; $display("FAIL sat2_flush: got narrow=%0d wide=%0d expected 3/4",
                               p2_flush, flush_count);
        end
        force dut.stall_cycles_q = 16'hFFFF;
        #1;
        release dut.stall_cycles_q;
        set_load_use();
        cyc();
        set_idle();
        #1;
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            errors++; $display("FAIL sat16_stall: got %h expected ffff", stall_cycles);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
